aes_round_ctrl: RTL

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: drives LOAD/ROUND/FINAL strobes to an iterative AES datapath and
// hands the ciphertext off with a valid/ready handshake. Optional: `AES_BACK2BACK_EN.
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        abort,
  output logic        dp_load,
  output logic        dp_round_en,
  output logic        dp_final,
  output logic [3:0]  dp_round_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [15:0] blk_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NR - 1);
  localparam logic [3:0] FINAL_IDX = 4'(NR);

  state_t      state_r;
  logic        in_ready_r;
  logic        dp_load_r;
  logic        dp_round_en_r;
  logic        dp_final_r;
  logic [3:0]  dp_round_idx_r;
  logic        out_valid_r;
  logic        busy_r;
  logic [15:0] blk_cnt_r;

  // State sequencing with all strobes registered alongside the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      in_ready_r     <= 1'b1;
      dp_load_r      <= 1'b0;
      dp_round_en_r  <= 1'b0;
      dp_final_r     <= 1'b0;
      dp_round_idx_r <= 4'd0;
      out_valid_r    <= 1'b0;
      busy_r         <= 1'b0;
      blk_cnt_r      <= 16'd0;
    end else if (abort) begin
      // Cancel drops any result, including one being handshaken this cycle.
      state_r        <= IDLE;
      in_ready_r     <= 1'b1;
      dp_load_r      <= 1'b0;
      dp_round_en_r  <= 1'b0;
      dp_final_r     <= 1'b0;
      dp_round_idx_r <= 4'd0;
      out_valid_r    <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      dp_load_r     <= 1'b0;
      dp_round_en_r <= 1'b0;
      dp_final_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            state_r        <= LOAD;
            in_ready_r     <= 1'b0;
            dp_load_r      <= 1'b1;
            dp_round_idx_r <= 4'd0;
            busy_r         <= 1'b1;
          end else begin
            state_r        <= IDLE;
            in_ready_r     <= 1'b1;
            dp_round_idx_r <= 4'd0;
            busy_r         <= 1'b0;
          end
        end
        LOAD: begin
          state_r        <= ROUND;
          dp_round_en_r  <= 1'b1;
          dp_round_idx_r <= 4'd1;
        end
        ROUND: begin
          dp_round_en_r <= 1'b1;
          if (dp_round_idx_r == LAST_IDX) begin
            state_r        <= FINAL;
            dp_final_r     <= 1'b1;
            dp_round_idx_r <= FINAL_IDX;
          end else begin
            state_r        <= ROUND;
            dp_round_idx_r <= dp_round_idx_r + 4'd1;
          end
        end
        FINAL: begin
          state_r        <= DONE;
          dp_round_idx_r <= 4'd0;
          out_valid_r    <= 1'b1;
        end
        DONE: begin
          dp_round_idx_r <= 4'd0;
          if (out_ready) begin
            blk_cnt_r   <= blk_cnt_r + 16'd1;
            out_valid_r <= 1'b0;
`ifdef AES_BACK2BACK_EN
            if (in_valid) begin
              state_r    <= LOAD;
              in_ready_r <= 1'b0;
              dp_load_r  <= 1'b1;
              busy_r     <= 1'b1;
            end else begin
              state_r    <= IDLE;
              in_ready_r <= 1'b1;
              busy_r     <= 1'b0;
            end
`else
            state_r    <= IDLE;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
`endif
          end else begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r        <= IDLE;
          in_ready_r     <= 1'b1;
          dp_round_idx_r <= 4'd0;
          out_valid_r    <= 1'b0;
          busy_r         <= 1'b0;
        end
      endcase
    end
  end

`ifdef AES_BACK2BACK_EN
  // In DONE the next block can only be taken on the cycle the current one leaves.
  assign in_ready = (state_r == DONE) ? out_ready : in_ready_r;
`else
  assign in_ready = in_ready_r;
`endif

  assign dp_load      = dp_load_r;
  assign dp_round_en  = dp_round_en_r;
  assign dp_final     = dp_final_r;
  assign dp_round_idx = dp_round_idx_r;
  assign out_valid    = out_valid_r;
  assign busy         = busy_r;
  assign blk_cnt      = blk_cnt_r;

endmodule
